vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Produces the raster timing that every sprite and background renderer consumes: DrawX, DrawY, active-video flag `blank`, and hs/vs for the VGA connector.
- Sits at the top of the video path, clocked by vga_clk. Pixel advance is gated by a clock-enable, so it runs from a divided system clock or a true pixel clock.
- Also emits line/frame strobes and a frame counter for animation sequencing (e.g. sword swing frames).

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of hs/vs (0 = active-low)

Ports:
- vga_clk  input  1  pixel-domain clock; all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- pix_ce  input  1  pixel tick; counters and outputs advance only on edges where pix_ce=1
- DrawX  output  10  current horizontal count, 0..H_TOTAL-1
- DrawY  output  10  current vertical count, 0..V_TOTAL-1
- blank  output  1  1 = visible pixel (renderers drive colour only when 1), 0 = blanking
- hs  output  1  horizontal sync
- vs  output  1  vertical sync
- line_start  output  1  one-vga_clk strobe when DrawX becomes 0
- frame_start  output  1  one-vga_clk strobe when (DrawX,DrawY) becomes (0,0)
- frame_count  output  8  completed-frame counter, wraps 255->0

Behaviour:
- Clocking and reset:
  - One clock (vga_clk). Reset is asynchronous, active-low.
- Totals:
  - H_TOTAL = sum of the four H parameters (800 at default).
  - V_TOTAL = sum of the four V parameters (525 at default).
- Reset values while reset_n=0:
  - DrawX=0, DrawY=0, blank=0, hs=vs=~SYNC_ACTIVE, line_start=0, frame_start=0, frame_count=0.
  - Internal `running` flag = 0.
- First tick after reset release (running=0, pix_ce=1):
  - Load the (0,0) state: DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1. Set running=1.
  - frame_count does not increment.
- Each later pix_ce=1 edge:
  - DrawX <= DrawX+1.
  - If DrawX = H_TOTAL-1: DrawX <= 0 and DrawY <= DrawY+1.
  - If DrawY = V_TOTAL-1 at that wrap: DrawY <= 0 and frame_count <= frame_count+1 (mod 256).
- pix_ce=0 edges:
  - All counters and hs/vs/blank hold.
  - line_start and frame_start clear to 0.
- Decode (all outputs registered, aligned with the DrawX/DrawY being loaded, no skew):
  - blank = (X < H_VISIBLE) && (Y < V_VISIBLE)
  - hs = SYNC_ACTIVE when H_VISIBLE+H_FRONT <= X < H_VISIBLE+H_FRONT+H_SYNC (656..751 default); else inverse
  - vs = SYNC_ACTIVE when V_VISIBLE+V_FRONT <= Y < V_VISIBLE+V_FRONT+V_SYNC (490..491 default); else inverse
- Strobes:
  - line_start and frame_start are high exactly one vga_clk cycle: the cycle after the edge that loaded X=0 (and Y=0 for frame_start).
  - They are low otherwise, even if pix_ce is held continuously high.
- Simultaneous events: at the (799,524)->(0,0) wrap, line_start, frame_start and the frame_count increment all occur on the same edge.
- Reset mid-frame: asynchronous return to the reset values. Restart obeys the first-tick rule above, with no partial frame counted.
- Width rule: 10-bit counters. Elaboration error if H_TOTAL > 1024 or V_TOTAL > 1024.

Test Plan:
- Reset release, pix_ce=1 constant → first edge gives DrawX=0, DrawY=0, blank=1, line_start=frame_start=1, frame_count=0; next edge gives DrawX=1, both strobes 0.
- Run one line at defaults → blank falls on the edge loading X=640; hs goes low at X=656 and high at X=752; at X=799→0, DrawY goes 0→1 and line_start pulses once.
- Run a full frame → vs low only for Y=490..491; blank=0 for all Y≥480; at the (799,524)→(0,0) edge, frame_count 0→1 and frame_start pulses; total ticks between frame_starts = 420000.
- pix_ce asserted every 2nd vga_clk → DrawX advances every 2 cycles; strobes stay one vga_clk wide; hs high period = 1408 vga_clk cycles per line.
- Assert reset_n=0 at (300,200) for 3 cycles → outputs immediately at reset values; after release, first tick gives (0,0) with frame_start=1 and frame_count=0.
- Preload frame_count to 255 by running 255 frames (or a bench force) → next wrap gives frame_count=0.

Source files
------------

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster timing bundle between the timing generator and the
// renderers / VGA connector.
//   pix_ce       pixel tick into the generator
//   DrawX/DrawY  current raster position (10 bits each)
//   blank        1 = visible pixel, 0 = blanking
//   hs/vs        horizontal / vertical sync
//   line_start   one-clock strobe when DrawX becomes 0
//   frame_start  one-clock strobe when (DrawX,DrawY) becomes (0,0)
//   frame_count  completed-frame counter, wraps 255->0
// The master modport is the generator side; slave is the consumer side.
interface vga_timing_if;
    logic       pix_ce;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;

    modport master (
        input  pix_ce,
        output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );

    modport slave (
        output pix_ce,
        input  DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
// Ports:
//   vga_clk  pixel-domain clock, all state on the rising edge
//   reset_n  asynchronous active-low reset
//   vga      vga_timing_if.master: pix_ce in; DrawX, DrawY, blank, hs, vs,
//            line_start, frame_start, frame_count out
// Counters and decoded outputs advance only on edges with pix_ce=1. All
// outputs are registered together, so blank/hs/vs always describe the
// DrawX/DrawY currently presented.
module vga_timing_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int SYNC_ACTIVE = 0
) (
    input logic          vga_clk,
    input logic          reset_n,
    vga_timing_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
        end
    endgenerate

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Region bounds held in 11 bits so an end bound of 1024 does not wrap.
    localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
    localparam logic [10:0] HS_BEG    = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
    localparam logic [10:0] VS_BEG    = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic SYNC_ON  = (SYNC_ACTIVE != 0);
    localparam logic SYNC_OFF = ~SYNC_ON;

    function automatic logic visible_at(input logic [9:0] x, input logic [9:0] y);
        return ({1'b0, x} < H_VIS_END) && ({1'b0, y} < V_VIS_END);
    endfunction

    function automatic logic hs_at(input logic [9:0] x);
        return ({1'b0, x} >= HS_BEG && {1'b0, x} < HS_END) ? SYNC_ON : SYNC_OFF;
    endfunction

    function automatic logic vs_at(input logic [9:0] y);
        return ({1'b0, y} >= VS_BEG && {1'b0, y} < VS_END) ? SYNC_ON : SYNC_OFF;
    endfunction

    logic       running;
    logic [9:0] x_q;
    logic [9:0] y_q;
    logic       blank_q;
    logic       hs_q;
    logic       vs_q;
    logic       line_start_q;
    logic       frame_start_q;
    logic [7:0] frame_count_q;

    logic [9:0] x_ld;
    logic [9:0] y_ld;
    logic       line_ld;
    logic       frame_ld;
    logic       count_inc;

    // Next raster position. Before the first tick the generator parks at
    // (0,0) and that tick re-loads (0,0) with both strobes, without counting
    // a frame.
    always_comb begin
        x_ld      = 10'd0;
        y_ld      = 10'd0;
        line_ld   = 1'b1;
        frame_ld  = 1'b1;
        count_inc = 1'b0;
        if (running) begin
            if (x_q == H_LAST) begin
                x_ld = 10'd0;
                if (y_q == V_LAST) begin
                    y_ld      = 10'd0;
                    count_inc = 1'b1;
                end else begin
                    y_ld     = y_q + 10'd1;
                    frame_ld = 1'b0;
                end
            end else begin
                x_ld     = x_q + 10'd1;
                y_ld     = y_q;
                line_ld  = 1'b0;
                frame_ld = 1'b0;
            end
        end
    end

    // Registered position, decode and strobes, all loaded on the same edge.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            running       <= 1'b0;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            blank_q       <= 1'b0;
            hs_q          <= SYNC_OFF;
            vs_q          <= SYNC_OFF;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
        end else if (vga.pix_ce) begin
            running       <= 1'b1;
            x_q           <= x_ld;
            y_q           <= y_ld;
            blank_q       <= visible_at(x_ld, y_ld);
            hs_q          <= hs_at(x_ld);
            vs_q          <= vs_at(y_ld);
            line_start_q  <= line_ld;
            frame_start_q <= frame_ld;
            if (count_inc) begin
                frame_count_q <= frame_count_q + 8'd1;
            end
        end else begin
            // Strobes last one vga_clk, even when pix_ce is a divided tick.
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

    assign vga.DrawX       = x_q;
    assign vga.DrawY       = y_q;
    assign vga.blank       = blank_q;
    assign vga.hs          = hs_q;
    assign vga.vs          = vs_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen, built with a reduced raster so whole frames and
// the 255->0 frame_count wrap stay short:
//   H: visible 10, front 2, sync 3, back 2 -> H_TOTAL 17, hs low at X=12..14
//   V: visible 6,  front 1, sync 2, back 1 -> V_TOTAL 10, vs low at Y=7..8
//   frame = 170 ticks
module tb_vga_timing_gen;

    localparam int HT    = 17;
    localparam int FRAME = 170;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;

    vga_timing_if vga();

    vga_timing_gen #(
        .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_ACTIVE(0)
    ) dut (
        .vga_clk(vga_clk),
        .reset_n(reset_n),
        .vga(vga)
    );

    always #5 vga_clk = ~vga_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int x, input int y, input int blank,
                             input int hs, input int vs, input int ls, input int fs,
                             input int fc);
        check({tag, ".DrawX"},       32'(vga.DrawX),       x);
        check({tag, ".DrawY"},       32'(vga.DrawY),       y);
        check({tag, ".blank"},       32'(vga.blank),       blank);
        check({tag, ".hs"},          32'(vga.hs),          hs);
        check({tag, ".vs"},          32'(vga.vs),          vs);
        check({tag, ".line_start"},  32'(vga.line_start),  ls);
        check({tag, ".frame_start"}, 32'(vga.frame_start), fs);
        check({tag, ".frame_count"}, 32'(vga.frame_count), fc);
    endtask

    typedef struct {
        int t;      // tick index since reset release (0 = first tick)
        int x;
        int y;
        int blank;
        int hs;
        int vs;
        int ls;
        int fs;
        int fc;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int t;
        int found;
        int hs_cnt;
        int ls_cnt;
        int fs_cnt;

        //           t    x  y  bl hs vs ls fs fc
        vecs[0]  = '{0,   0, 0, 1, 1, 1, 1, 1, 0};
        vecs[1]  = '{1,   1, 0, 1, 1, 1, 0, 0, 0};
        vecs[2]  = '{9,   9, 0, 1, 1, 1, 0, 0, 0};
        vecs[3]  = '{10, 10, 0, 0, 1, 1, 0, 0, 0};
        vecs[4]  = '{11, 11, 0, 0, 1, 1, 0, 0, 0};
        vecs[5]  = '{12, 12, 0, 0, 0, 1, 0, 0, 0};
        vecs[6]  = '{14, 14, 0, 0, 0, 1, 0, 0, 0};
        vecs[7]  = '{15, 15, 0, 0, 1, 1, 0, 0, 0};
        vecs[8]  = '{16, 16, 0, 0, 1, 1, 0, 0, 0};
        vecs[9]  = '{17,  0, 1, 1, 1, 1, 1, 0, 0};
        vecs[10] = '{18,  1, 1, 1, 1, 1, 0, 0, 0};
        vecs[11] = '{101, 16, 5, 0, 1, 1, 0, 0, 0};
        vecs[12] = '{102,  0, 6, 0, 1, 1, 1, 0, 0};
        vecs[13] = '{118, 16, 6, 0, 1, 1, 0, 0, 0};
        vecs[14] = '{119,  0, 7, 0, 1, 0, 1, 0, 0};
        vecs[15] = '{152, 16, 8, 0, 1, 0, 0, 0, 0};
        vecs[16] = '{153,  0, 9, 0, 1, 1, 1, 0, 0};
        vecs[17] = '{169, 16, 9, 0, 1, 1, 0, 0, 0};
        vecs[18] = '{170,  0, 0, 1, 1, 1, 1, 1, 1};
        vecs[19] = '{171,  1, 0, 1, 1, 1, 0, 0, 1};

        // Reset with pix_ce high: everything at reset values.
        vga.pix_ce = 1'b1;
        reset_n    = 1'b0;
        repeat (3) @(negedge vga_clk);
        check_all("rst", 0, 0, 0, 1, 1, 0, 0, 0);

        // Released but no tick yet: still parked.
        vga.pix_ce = 1'b0;
        reset_n    = 1'b1;
        repeat (3) @(negedge vga_clk);
        check_all("idle", 0, 0, 0, 1, 1, 0, 0, 0);

        // Continuous pix_ce through one full frame.
        vga.pix_ce = 1'b1;
        t = -1;
        for (int i = 0; i < NV; i++) begin
            while (t < vecs[i].t) begin
                @(negedge vga_clk);
                t++;
            end
            check_all($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].blank,
                      vecs[i].hs, vecs[i].vs, vecs[i].ls, vecs[i].fs, vecs[i].fc);
        end

        // pix_ce every second vga_clk: one line spans 34 clocks.
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            @(negedge vga_clk);
            if (vga.line_start === 1'b1) found = 1;
            vga.pix_ce = ~vga.pix_ce;
        end
        check("half.found", 32'(found), 1);
        check("half.x0", 32'(vga.DrawX), 0);
        hs_cnt = int'(vga.hs);
        ls_cnt = 1;
        for (int k = 1; k < 2 * HT; k++) begin
            @(negedge vga_clk);
            hs_cnt += int'(vga.hs);
            ls_cnt += int'(vga.line_start);
            if (k == 1) check("half.hold_x", 32'(vga.DrawX), 0);
            if (k == 2) check("half.step_x", 32'(vga.DrawX), 1);
            vga.pix_ce = ~vga.pix_ce;
        end
        check("half.hs_high_clks", 32'(hs_cnt), 28);
        check("half.ls_clks", 32'(ls_cnt), 1);
        @(negedge vga_clk);
        check("half.period_ls", 32'(vga.line_start), 1);
        check("half.period_x", 32'(vga.DrawX), 0);

        // Mid-frame asynchronous reset at (5,3).
        vga.pix_ce = 1'b1;
        found = 0;
        for (int k = 0; k < 400 && found == 0; k++) begin
            @(negedge vga_clk);
            if (vga.DrawX == 10'd5 && vga.DrawY == 10'd3) found = 1;
        end
        check("mid.found", 32'(found), 1);
        check("mid.fc", 32'(vga.frame_count), 1);
        reset_n = 1'b0;
        #1;
        check_all("async", 0, 0, 0, 1, 1, 0, 0, 0);
        repeat (3) @(negedge vga_clk);
        check_all("rst_hold", 0, 0, 0, 1, 1, 0, 0, 0);
        reset_n = 1'b1;
        @(negedge vga_clk);
        check_all("restart", 0, 0, 1, 1, 1, 1, 1, 0);
        @(negedge vga_clk);
        check_all("restart1", 1, 0, 1, 1, 1, 0, 0, 0);

        // 255 more frames: one frame_start per 170 ticks, count reaches 255.
        fs_cnt = 0;
        for (int k = 2; k <= 255 * FRAME; k++) begin
            @(negedge vga_clk);
            fs_cnt += int'(vga.frame_start);
        end
        check("wrap.fs_pulses", 32'(fs_cnt), 255);
        check_all("fc255", 0, 0, 1, 1, 1, 1, 1, 255);
        repeat (FRAME) @(negedge vga_clk);
        check_all("fc_wrap", 0, 0, 1, 1, 1, 1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
